// File: rtl/gps_pkg.sv
// Shared GPS channel types: code length, phase type, and
// the acquisition search FSM state encoding.
package gps_pkg;

    localparam int CHIPS_PER_CODE = 1023;

    typedef logic [9:0] phase_t;

    localparam phase_t LAST_PHASE = 10'd1022;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_EVAL,
        S_DONE
    } search_state_t;

    // |k| of a two's complement dump; -2^31 folds to 2^31-1
    function automatic logic [31:0] dump_mag(
        input logic [31:0] k
    );
        logic [31:0] neg;
        neg = ~k + 32'd1;
        if (k == 32'h8000_0000) begin
            return 32'h7FFF_FFFF;
        end
        return k[31] ? neg : k;
    endfunction

endpackage

// File: rtl/dump_sync.sv
// Two-flop synchronizer plus rising-edge detector for the
// correlator dump epoch. Ports: CLK_16M, rst (async low),
// clk_10k (async level in), dump_pulse (1-cycle out).
module dump_sync (
    input  logic CLK_16M,
    input  logic rst,
    input  logic clk_10k,
    output logic dump_pulse
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge CLK_16M or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_10k;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign dump_pulse = s2_q & ~s3_q;

endmodule

// File: rtl/code_phase_search.sv
// Serial C/A code-phase acquisition: sweeps 1023 phases,
// integrates |koef| per phase, reports best phase/energy.
// Ports: CLK_16M, rst (async low), clk_10k, koef, start in;
// Phase, busy, done, locked, best_phase, best_mag out.
module code_phase_search
    import gps_pkg::*;
#(
    parameter int          SETTLE_DUMPS = 1,
    parameter int          DWELL_DUMPS  = 4,
    parameter logic [31:0] THRESHOLD    = 32'd4000
) (
    input  logic        CLK_16M,
    input  logic        rst,
    input  logic        clk_10k,
    input  logic [31:0] koef,
    input  logic        start,
    output logic [9:0]  Phase,
    output logic        busy,
    output logic        done,
    output logic        locked,
    output logic [9:0]  best_phase,
    output logic [31:0] best_mag
);

    localparam int CNT_W = 8;

    localparam logic [CNT_W-1:0] SETTLE_LAST =
        CNT_W'((SETTLE_DUMPS > 0) ? SETTLE_DUMPS - 1 : 0);
    localparam logic [CNT_W-1:0] DWELL_LAST =
        CNT_W'((DWELL_DUMPS > 0) ? DWELL_DUMPS - 1 : 0);

    search_state_t state_q, state_d;
    phase_t        phase_q, phase_d;
    phase_t        bphase_q, bphase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   bmag_q, bmag_d;
    logic          locked_q, locked_d;

    logic          dump_pulse;
    logic [31:0]   mag;
    logic [32:0]   sum;
    logic [31:0]   acc_sat;
    logic [31:0]   new_best;

    dump_sync u_sync (
        .CLK_16M    (CLK_16M),
        .rst        (rst),
        .clk_10k    (clk_10k),
        .dump_pulse (dump_pulse)
    );

    assign mag      = dump_mag(koef);
    assign sum      = {1'b0, acc_q} + {1'b0, mag};
    assign acc_sat  = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    // strict compare keeps the earlier phase on a tie
    assign new_best = (acc_q > bmag_q) ? acc_q : bmag_q;

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        bphase_d = bphase_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        bmag_d   = bmag_q;
        locked_d = locked_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    phase_d  = '0;
                    bphase_d = '0;
                    bmag_d   = '0;
                    locked_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (SETTLE_DUMPS == 0) begin
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_MEASURE;
                end else if (dump_pulse) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        acc_d   = '0;
                        state_d = S_MEASURE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_MEASURE: begin
                if (dump_pulse) begin
                    acc_d = acc_sat;
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d   = '0;
                        state_d = S_EVAL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_EVAL: begin
                if (acc_q > bmag_q) begin
                    bmag_d   = acc_q;
                    bphase_d = phase_q;
                end
                if (phase_q == LAST_PHASE) begin
                    // settle lock here so it is valid with done
                    locked_d = (new_best >= THRESHOLD);
                    state_d  = S_DONE;
                end else begin
                    phase_d = phase_q + 10'd1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                locked_d = (bmag_q >= THRESHOLD);
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_16M or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            bphase_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            bmag_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            bphase_q <= bphase_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bmag_q   <= bmag_d;
            locked_q <= locked_d;
        end
    end

    assign Phase      = phase_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign locked     = locked_q;
    assign best_phase = bphase_q;
    assign best_mag   = bmag_q;

endmodule

// File: doc/code_phase_search.md
# code_phase_search

Serial code-phase acquisition controller for one GPS channel. It sits directly downstream of the channel correlator and consumes the signed 32-bit dump `koef` produced at every `clk_10k` epoch. It also drives the correlator's `Phase` input. It sweeps all 1023 C/A chip phases, non-coherently integrates |koef| over a dwell at each phase, and reports the strongest phase, its energy, and a lock decision against a threshold.

## Interface
Parameters:
- `SETTLE_DUMPS`, default 1: dumps discarded after every phase change, because the accumulator window straddles two phases.
- `DWELL_DUMPS`, default 4: dumps integrated per phase, range 1..16.
- `THRESHOLD`, default 32'd4000: minimum best energy required to declare lock.

Ports:
- `CLK_16M`, input, 1: single system clock; all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `clk_10k`, input, 1: correlator dump epoch; asynchronous to `CLK_16M` and treated as a level.
- `koef`, input, 32: correlator dump, signed two's complement.
- `start`, input, 1: single-cycle request to begin a sweep; ignored while `busy`.
- `Phase`, output, 10: code phase driven to the correlator.
- `busy`, output, 1: high while a sweep is in progress.
- `done`, output, 1: one-cycle pulse when a sweep completes.
- `locked`, output, 1: `best_mag >= THRESHOLD`; valid from `done` until the next `start`.
- `best_phase`, output, 10: phase with the largest dwell energy.
- `best_mag`, output, 32: dwell energy at `best_phase`, unsigned and saturating.

## Operation
- **Dump detection.** `clk_10k` passes through a two-flop synchronizer. A rising edge on the synchronized signal produces `dump_pulse`, one `CLK_16M` cycle wide. `koef` is sampled only in the `dump_pulse` cycle.
- **Magnitude.** `mag = koef[31] ? -koef : koef`. The value -2^31 maps to 2^31-1.
- **Dwell energy.** The running energy `acc` is a 32-bit unsigned saturating sum of `mag`. It clamps at 0xFFFF_FFFF.
- **FSM states:**
  - IDLE: wait for `start`.
  - SETTLE: discard dumps.
  - MEASURE: integrate dumps into `acc`.
  - EVAL: compare and advance.
  - DONE: report the result.
- **IDLE -> SETTLE** on `start`:
  - `Phase` = 0, `best_mag` = 0, `best_phase` = 0, `locked` = 0, `busy` = 1.
  - The settle and dwell counters clear.
- **SETTLE -> MEASURE** after `SETTLE_DUMPS` dump pulses. These dumps are not accumulated. `acc` clears on entry to MEASURE.
- **MEASURE -> EVAL** after `DWELL_DUMPS` dump pulses have been accumulated.
- **EVAL** lasts exactly one cycle:
  - If `acc > best_mag` (strictly greater), then `best_mag` <= `acc` and `best_phase` <= `Phase`. On a tie the earlier phase is kept.
  - If `Phase == 1022`, go to DONE.
  - Otherwise `Phase` <= `Phase + 1` and go to SETTLE.
- **DONE** lasts one cycle:
  - `done` = 1 and `busy` <= 0.
  - `locked` <= `best_mag >= THRESHOLD`.
  - Then return to IDLE.
- **Holding values.** `Phase` holds its last value (1022) in IDLE. It is never driven to 1023.
- **Reset mid-sweep.** Asserting `rst` during a sweep forces IDLE immediately. No `done` pulse is issued.
- **Reset values:** `Phase` = 0, `busy` = 0, `done` = 0, `locked` = 0, `best_phase` = 0, `best_mag` = 0; synchronizer flops = 0; FSM = IDLE.
- **Simultaneous events:**
  - `start` together with `dump_pulse` while in IDLE: the dump is ignored, and counting begins with the next dump.
  - `start` while `busy`: no effect.
  - `dump_pulse` during EVAL or DONE: dropped. This cannot occur in practice, since dumps are 1600 cycles apart.

## Timing
- `dump_pulse` is asserted on the 3rd `CLK_16M` rising edge after the `clk_10k` rising edge, within ±1 cycle of synchronizer uncertainty.
- `koef` must be stable from 1 cycle before `dump_pulse` through the `dump_pulse` cycle.
- `Phase` changes in the cycle after EVAL. The correlator picks the new value up on its next `clk_1_023M` edge; this latency is absorbed by SETTLE.
- A sweep lasts 1023 × (`SETTLE_DUMPS` + `DWELL_DUMPS`) dump periods. With the defaults this is 5115 periods, about 511.5 ms.
- `best_*` update 1 cycle after the final MEASURE dump. `done` follows 1 cycle later. `locked` is valid in the same cycle as `done`.

## Structure
- Shared package `gps_pkg`:
  - `CHIPS_PER_CODE` = 1023 and `LAST_PHASE` = 10'd1022.
  - The `search_state_t` enum.
  - The `phase_t` typedef, `logic [9:0]`.
- Sub-module `dump_sync`: two-flop synchronizer plus rising-edge detector, with ports `CLK_16M`, `rst`, `clk_10k`, and `dump_pulse`. It is reusable by the tracking loop.
- The FSM, counters, and compare logic live in `code_phase_search`.

## Test plan
- **Reset.** Hold `rst` = 0 with `clk_10k` toggling. Expect all outputs 0 and `busy` = 0. No output changes after release until `start`.
- **Single peak.** Model the correlator so `koef` = 1500 when `Phase` = 317 and ±20 otherwise, then pulse `start`. Expect `best_phase` = 317, `best_mag` = 6000, `locked` = 1, one `done` pulse, and `busy` low after 5115 dumps.
- **Negative peak and tie.** `koef` = -2000 at phase 12 and +2000 at phase 900; all other phases 0. Expect `best_phase` = 12 (earlier phase on a tie) and `best_mag` = 8000.
- **No signal.** `koef` = 900 at every phase. Expect `best_mag` = 3600, `best_phase` = 0, `locked` = 0.
- **Saturation.** `koef` = -2^31 at phase 5. Expect `mag` = 0x7FFF_FFFF per dump and `best_mag` = 0xFFFF_FFFF (clamped).
- **Abort and restart.**
  - Assert `rst` at phase 400. Expect `busy` = 0 and `Phase` = 0 asynchronously, with no `done` pulse.
  - Pulse `start` again, plus a second `start` mid-sweep. The second `start` is ignored, and the sweep completes normally.
